cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Run/step controller for the MIPS CPU on the board. Consumes the debounced one-cycle
//  button pulses and stable switches from the input-conditioning stage and produces
//  the single-cycle CPU clock enable (cpu_ce).
//  Modes: halt, free-run at switch-selected speed, single-step, N-step burst.
//  Includes a PC breakpoint and a saturating executed-step counter for the display.
// PARAMETERS
//  CNT_W  32  width of step_cnt
//  DIV_W  24  run-rate divider width; must be >= 21
//  PC_W   32  width of pc / bp_addr
// PORTS
//  clk           in   1      system clock
//  rst           in   1      synchronous reset, active-high
//  button_pulse  in   4      one-cycle pulses: [0] run/stop, [1] step, [2] burst, [3] clear count
//  SW_OK         in   8      [2:0] speed sel, [7:4] burst length (0 means 16), [3] unused
//  pc            in   PC_W   PC of the instruction the next cpu_ce will execute
//  bp_addr       in   PC_W   breakpoint address
//  bp_en         in   1      breakpoint enable
//  cpu_ce        out  1      CPU clock enable, one pulse per instruction
//  state         out  2      00 HALT, 01 RUN, 10 STEP, 11 BURST (registered)
//  step_cnt      out  CNT_W  executed cpu_ce count, saturating
//  burst_rem     out  5      remaining burst steps
//  bp_hit        out  1      sticky breakpoint-stop flag
// BEHAVIOUR
//  Reset, checked at clk edge:
//   - state=HALT; step_cnt=0, burst_rem=0, bp_hit=0; internal div_cnt=0, bp_skip=0.
//   - cpu_ce=0 in the cycle following a reset edge.
//   - Reset mid-RUN/BURST gives no further cpu_ce.
//  Divider:
//   - limit = 2^(3*SW_OK[2:0]) - 1 (sel 0 ticks every cycle; sel 7 every 2^21 cycles).
//   - In RUN/BURST, div_cnt increments; tick when div_cnt >= limit, then div_cnt <= 0.
//     The >= compare covers a speed change that lowers limit below div_cnt.
//   - div_cnt <= 0 on every entry to RUN/BURST.
//  cpu_ce:
//   - Combinational from registered state: 1 in STEP, or in RUN/BURST when tick and not bp_stop.
//   - bp_stop = bp_en & (pc==bp_addr) & ~bp_skip & tick & state in {RUN, BURST}.
//  Transitions:
//   - HALT: simultaneous pulses resolve by priority [0]>[1]>[2].
//     [0] -> RUN; [1] -> STEP; [2] -> BURST, burst_rem <= SW_OK[7:4] (0 loads 16).
//   - STEP: lasts exactly one cycle, cpu_ce=1, then -> HALT.
//     Latency: pulse at edge N, cpu_ce high in cycle N..N+1, state HALT after edge N+1.
//   - RUN: [0] -> HALT. A tick in the same cycle still issues cpu_ce. [1]/[2] ignored.
//   - BURST: each cpu_ce decrements burst_rem; on the cpu_ce that takes it 1->0, next state HALT.
//     [0] aborts -> HALT, burst_rem <= 0. [1]/[2] ignored.
//   - bp_stop (RUN/BURST): cpu_ce suppressed, -> HALT, bp_hit <= 1, burst_rem held.
//  Breakpoint:
//   - bp_skip <= 1 on any exit from HALT; cleared on the first cpu_ce.
//     So resuming from the breakpoint executes the bp instruction.
//   - bp_hit cleared by a button_pulse [0], [1] or [2] accepted in HALT, or by rst.
//  step_cnt:
//   - +1 per cpu_ce, saturating at all ones.
//   - [3] clears it in any state; clear wins over a same-cycle cpu_ce.
//  Mode pulses arriving in STEP are ignored.
// TESTING
//  1. rst; [1] pulse at edge 10 -> cpu_ce=1 only between edges 10 and 11; step_cnt=1; state HALT at 11.
//  2. SW_OK=8'h01, [0] -> cpu_ce every 8 cycles; after 5 pulses, [0] -> HALT, step_cnt=5, no more ce.
//  3. SW_OK=8'h00, [2] -> 16 consecutive ce then HALT, burst_rem=0.
//     SW_OK=8'h30 -> exactly 3 ce.
//  4. bp_en=1, bp_addr=32'h10, pc model +4 per ce from 0, [0] -> 4 ce (pc 0..C), HALT, bp_hit=1.
//     [0] again -> ce at pc 10 issued, bp_hit=0.
//  5. RUN speed 0: [3] coincident with ce -> step_cnt=0 next cycle.
//     rst during burst -> HALT, cpu_ce=0 from next cycle.
//  6. CNT_W=4: 20 single steps -> step_cnt=4'hF, holds.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step controller: turns conditioned button pulses and switches into a
// single-cycle CPU clock enable, with free-run, single-step and N-step burst
// modes, a PC breakpoint and a saturating executed-instruction counter.
module cpu_run_ctrl #(
  parameter int CNT_W = 32,
  parameter int DIV_W = 24,  // must hold 2^21 - 1, the slowest run-rate limit
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       button_pulse,
  input  logic [7:0]       SW_OK,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_en,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_cnt,
  output logic [4:0]       burst_rem,
  output logic             bp_hit
);

  typedef enum logic [1:0] {
    HALT  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BURST = 2'b11
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] limit;
  logic [4:0]       shamt;
  logic             bp_skip;
  logic             active;
  logic             tick;
  logic             bp_stop;
  logic             unused_sw;

  assign state     = state_q;
  assign unused_sw = SW_OK[3];

  // Run-rate divider compare, breakpoint detect and clock-enable decode
  always_comb begin
    shamt   = {2'b00, SW_OK[2:0]} + {1'b0, SW_OK[2:0], 1'b0};
    limit   = (DIV_W'(1) << shamt) - DIV_W'(1);
    active  = (state_q == RUN) || (state_q == BURST);
    // >= rather than == so lowering the speed select mid-run cannot strand div_cnt above limit
    tick    = active && (div_cnt >= limit);
    bp_stop = bp_en && (pc == bp_addr) && !bp_skip && tick;
    cpu_ce  = (state_q == STEP) || (tick && !bp_stop);
  end

  // Mode FSM, divider, breakpoint bookkeeping and step counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HALT;
      div_cnt   <= '0;
      bp_skip   <= 1'b0;
      bp_hit    <= 1'b0;
      burst_rem <= '0;
      step_cnt  <= '0;
    end else begin
      // Held at zero outside RUN/BURST so every entry starts a fresh period
      if (active) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      end else begin
        div_cnt <= '0;
      end

      if (cpu_ce) begin
        bp_skip <= 1'b0;
      end

      if (button_pulse[3]) begin
        step_cnt <= '0;
      end else if (cpu_ce && (step_cnt != '1)) begin
        step_cnt <= step_cnt + CNT_W'(1);
      end

      case (state_q)
        HALT: begin
          if (button_pulse[0]) begin
            state_q <= RUN;
            bp_skip <= 1'b1;
            bp_hit  <= 1'b0;
          end else if (button_pulse[1]) begin
            state_q <= STEP;
            bp_skip <= 1'b1;
            bp_hit  <= 1'b0;
          end else if (button_pulse[2]) begin
            state_q   <= BURST;
            bp_skip   <= 1'b1;
            bp_hit    <= 1'b0;
            burst_rem <= (SW_OK[7:4] == 4'd0) ? 5'd16 : {1'b0, SW_OK[7:4]};
          end
        end
        STEP: begin
          state_q <= HALT;
        end
        RUN: begin
          if (bp_stop || button_pulse[0]) begin
            state_q <= HALT;
          end
          if (bp_stop) begin
            bp_hit <= 1'b1;
          end
        end
        BURST: begin
          if (button_pulse[0]) begin
            state_q   <= HALT;
            burst_rem <= '0;
          end else if (cpu_ce) begin
            burst_rem <= burst_rem - 5'd1;
            if (burst_rem == 5'd1) begin
              state_q <= HALT;
            end
          end
          // burst_rem is left untouched on a breakpoint stop (cpu_ce is low then)
          if (bp_stop) begin
            state_q <= HALT;
            bp_hit  <= 1'b1;
          end
        end
        default: begin
          state_q <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: step latency, run rate, bursts, breakpoint
// stop/resume, clear priority, reset mid-burst and counter saturation.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  button_pulse;
  logic [7:0]  SW_OK;
  logic [31:0] pc;
  logic [31:0] bp_addr;
  logic        bp_en;
  logic        pc_clr;

  logic        cpu_ce;
  logic [1:0]  state;
  logic [31:0] step_cnt;
  logic [4:0]  burst_rem;
  logic        bp_hit;

  logic        ce4;
  logic [1:0]  state4;
  logic [3:0]  cnt4;
  logic [4:0]  rem4;
  logic        hit4;

  int checks = 0;
  int errors = 0;
  int c;

  cpu_run_ctrl dut (
    .clk(clk), .rst(rst), .button_pulse(button_pulse), .SW_OK(SW_OK),
    .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .cpu_ce(cpu_ce), .state(state), .step_cnt(step_cnt),
    .burst_rem(burst_rem), .bp_hit(bp_hit)
  );

  cpu_run_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .button_pulse(button_pulse), .SW_OK(SW_OK),
    .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .cpu_ce(ce4), .state(state4), .step_cnt(cnt4),
    .burst_rem(rem4), .bp_hit(hit4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction fetch model: PC advances by one word per executed instruction
  always @(posedge clk) begin
    if (pc_clr) pc <= '0;
    else if (cpu_ce) pc <= pc + 32'd4;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle pulse sampled by exactly one rising edge; returns #1 after that edge
  task automatic pulse(input logic [3:0] m);
    @(posedge clk);
    #1 button_pulse = m;
    @(posedge clk);
    #1 button_pulse = '0;
  endtask

  task automatic count_ce(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cpu_ce) cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int idx[$];
    rst = 1'b1; button_pulse = '0; SW_OK = 8'h00; bp_addr = '0; bp_en = 1'b0; pc_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; pc_clr = 1'b0;
    check("rst_state", state, 2'b00);
    check("rst_ce", cpu_ce, 1'b0);
    check("rst_cnt", step_cnt, 0);
    check("rst_rem", burst_rem, 0);
    check("rst_hit", bp_hit, 0);

    // 1. single step latency
    pulse(4'b0010);
    check("step_ce", cpu_ce, 1'b1);
    check("step_state", state, 2'b10);
    @(posedge clk); #1;
    check("step_ce_after", cpu_ce, 1'b0);
    check("step_halt", state, 2'b00);
    check("step_cnt1", step_cnt, 1);
    pulse(4'b0110);
    check("prio_step_over_burst", state, 2'b10);
    @(posedge clk); #1;
    pulse(4'b0111);
    check("prio_run_first", state, 2'b01);
    pulse(4'b0001);
    check("run_stop", state, 2'b00);

    // 2. run at speed 1: one ce every 8 cycles
    pulse(4'b1000);
    check("clear_cnt", step_cnt, 0);
    SW_OK = 8'h01;
    pulse(4'b0001);
    for (int k = 0; k < 80 && idx.size() < 5; k++) begin
      @(negedge clk);
      if (cpu_ce) idx.push_back(k);
      @(posedge clk); #1;
    end
    check("run_ce_count", idx.size(), 5);
    if (idx.size() == 5) begin
      check("run_first_ce", idx[0], 7);
      check("run_period", idx[4] - idx[0], 32);
    end
    pulse(4'b0001);
    check("run_halt", state, 2'b00);
    check("run_cnt5", step_cnt, 5);
    count_ce(20, c);
    check("halt_no_ce", c, 0);

    // 3. bursts
    SW_OK = 8'h00;
    pulse(4'b0100);
    check("burst_state", state, 2'b11);
    check("burst_rem16", burst_rem, 16);
    count_ce(16, c);
    check("burst16_ce", c, 16);
    check("burst16_halt", state, 2'b00);
    check("burst16_rem", burst_rem, 0);
    SW_OK = 8'h30;
    pulse(4'b0100);
    check("burst3_rem", burst_rem, 3);
    count_ce(10, c);
    check("burst3_ce", c, 3);
    check("burst3_rem0", burst_rem, 0);

    // 4. breakpoint stop and resume
    SW_OK = 8'h00;
    pulse(4'b1000);
    pc_clr = 1'b1; @(posedge clk); #1 pc_clr = 1'b0;
    bp_en = 1'b1; bp_addr = 32'h10;
    pulse(4'b0001);
    count_ce(10, c);
    check("bp_ce", c, 4);
    check("bp_halt", state, 2'b00);
    check("bp_hit", bp_hit, 1'b1);
    check("bp_pc", pc, 32'h10);
    check("bp_cnt", step_cnt, 4);
    pulse(4'b0001);
    check("resume_ce", cpu_ce, 1'b1);
    check("resume_pc", pc, 32'h10);
    check("resume_hit_clr", bp_hit, 1'b0);
    pulse(4'b0001);
    check("resume_stop", state, 2'b00);
    bp_en = 1'b0;

    // 5. clear beats a coincident ce; reset mid-burst
    pulse(4'b0001);
    pulse(4'b1000);
    check("clr_coincident_ce", cpu_ce, 1'b1);
    check("clr_wins", step_cnt, 0);
    pulse(4'b0001);
    pulse(4'b0100);
    count_ce(3, c);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rstb_ce", cpu_ce, 1'b0);
    check("rstb_state", state, 2'b00);
    check("rstb_rem", burst_rem, 0);
    count_ce(5, c);
    check("rstb_no_ce", c, 0);

    // 6. saturation with a 4-bit counter
    pulse(4'b1000);
    check("sat_clr", cnt4, 0);
    for (int s = 0; s < 20; s++) pulse(4'b0010);
    @(posedge clk); #1;
    check("sat_hold", cnt4, 4'hF);
    check("sat_wide", step_cnt, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
